// File: rtl/noc_endp_addr_codec_if.sv
// Request/response bundle for the endpoint-address codec.
// Parameters: IDW - endpoint ID width, CW - address code width.
// Signals:
//   in_valid  request strobe (master -> slave)
//   op        0 fat-tree encode, 1 fat-tree decode, 2 fmesh encode, 3 fmesh decode
//   id_in     endpoint ID for encode ops
//   code_in   address code for decode ops
//   out_valid response strobe (slave -> master)
//   code_out  encode result
//   id_out    decode result
//   err       request was out of range or illegal
interface noc_endp_addr_codec_if #(
  parameter int IDW = 5,
  parameter int CW  = 7
);
  logic           in_valid;
  logic [1:0]     op;
  logic [IDW-1:0] id_in;
  logic [CW-1:0]  code_in;
  logic           out_valid;
  logic [CW-1:0]  code_out;
  logic [IDW-1:0] id_out;
  logic           err;

  modport master (
    output in_valid, op, id_in, code_in,
    input  out_valid, code_out, id_out, err
  );

  modport slave (
    input  in_valid, op, id_in, code_in,
    output out_valid, code_out, id_out, err
  );
endinterface

// File: rtl/noc_endp_addr_codec.sv
// Registered endpoint-address translation unit for fat-tree and fmesh NoCs.
// Converts a flat endpoint ID to a topology address code and back, with a
// fixed latency of one clock and no backpressure.
// Ports:
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    slave side of noc_endp_addr_codec_if (IDW/CW must match the
//          derived widths below)
module noc_endp_addr_codec #(
  parameter int K  = 4,
  parameter int L  = 2,
  parameter int NX = 3,
  parameter int NY = 3,
  parameter int NL = 1
) (
  input logic                 clk,
  input logic                 reset,
  noc_endp_addr_codec_if.slave bus
);

  function automatic int clog2m(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int KW    = clog2m(K);
  localparam int FTW   = L * KW;
  localparam int NE_T  = K ** L;
  localparam int XW    = clog2m(NX);
  localparam int YW    = clog2m(NY);
  localparam int P     = 4 + NL;
  localparam int PW    = clog2m(P);
  localparam int NLOC  = NX * NY * NL;
  localparam int NE_F  = NLOC + 2 * NX + 2 * NY;
  localparam int FMW   = XW + YW + PW;
  localparam int CW    = (FTW > FMW) ? FTW : FMW;
  localparam int IDW   = clog2m((NE_T > NE_F) ? NE_T : NE_F);

  localparam logic [31:0] K_U    = 32'(K);
  localparam logic [31:0] NE_T_U = 32'(NE_T);
  localparam logic [31:0] NX_U   = 32'(NX);
  localparam logic [31:0] NY_U   = 32'(NY);
  localparam logic [31:0] NL_U   = 32'(NL);
  localparam logic [31:0] P_U    = 32'(P);
  localparam logic [31:0] NE_F_U = 32'(NE_F);
  // First ID of each edge group: north, south, west, east.
  localparam logic [31:0] N_BASE = 32'(NLOC);
  localparam logic [31:0] S_BASE = 32'(NLOC + NX);
  localparam logic [31:0] W_BASE = 32'(NLOC + 2 * NX);
  localparam logic [31:0] E_BASE = 32'(NLOC + 2 * NX + NY);

  logic [31:0]    id32_s;
  logic [CW-1:0]  ft_code_s;
  logic           ft_enc_err_s;
  logic [31:0]    ft_rem_s;
  logic [IDW-1:0] ft_id_s;
  logic           ft_dec_err_s;
  logic [31:0]    ft_sum_s;
  logic [31:0]    ft_wt_s;
  logic [31:0]    ft_digit_s;
  logic [CW-1:0]  fm_code_s;
  logic           fm_enc_err_s;
  logic [31:0]    fe_r_s, fe_l_s, fe_x_s, fe_y_s, fe_el_s;
  logic [IDW-1:0] fm_id_s;
  logic           fm_dec_err_s;
  logic [31:0]    fd_x_s, fd_y_s, fd_el_s, fd_id_s;
  logic [CW-1:0]  nxt_code_s;
  logic [IDW-1:0] nxt_id_s;
  logic           nxt_err_s;
  logic           out_valid_r;
  logic [CW-1:0]  code_out_r;
  logic [IDW-1:0] id_out_r;
  logic           err_r;
  logic           unused_code_bits_s;

  assign id32_s = 32'(bus.id_in);
  // Code bits above the active field of each topology are ignored by design.
  assign unused_code_bits_s = ^bus.code_in;

  // Fat-tree encode: peel base-K digits off the ID, least significant first.
  always_comb begin
    ft_code_s    = '0;
    ft_enc_err_s = 1'b0;
    ft_rem_s     = id32_s;
    if (id32_s >= NE_T_U) begin
      ft_enc_err_s = 1'b1;
    end else begin
      for (int i = 0; i < L; i++) begin
        ft_code_s[i*KW +: KW] = KW'(ft_rem_s % K_U);
        ft_rem_s              = ft_rem_s / K_U;
      end
    end
  end

  // Fat-tree decode: weighted digit sum; a digit >= K (non power-of-two K) is illegal.
  always_comb begin
    ft_dec_err_s = 1'b0;
    ft_sum_s     = 32'd0;
    ft_wt_s      = 32'd1;
    ft_digit_s   = 32'd0;
    for (int i = 0; i < L; i++) begin
      ft_digit_s = 32'(bus.code_in[i*KW +: KW]);
      if (ft_digit_s >= K_U) begin
        ft_dec_err_s = 1'b1;
      end else begin
        ft_dec_err_s = ft_dec_err_s;
      end
      ft_sum_s = ft_sum_s + ft_digit_s * ft_wt_s;
      ft_wt_s  = ft_wt_s * K_U;
    end
    if (ft_dec_err_s) begin
      ft_id_s = '0;
    end else begin
      ft_id_s = IDW'(ft_sum_s);
    end
  end

  // fmesh encode: local endpoints first, then north/south/west/east edge groups.
  always_comb begin
    fm_enc_err_s = 1'b0;
    fe_r_s  = id32_s / NL_U;
    fe_l_s  = id32_s % NL_U;
    fe_x_s  = 32'd0;
    fe_y_s  = 32'd0;
    fe_el_s = 32'd0;
    if (id32_s >= NE_F_U) begin
      fm_enc_err_s = 1'b1;
    end else if (id32_s < N_BASE) begin
      fe_x_s  = fe_r_s % NX_U;
      fe_y_s  = fe_r_s / NX_U;
      // Port 0 is the primary local port; extra locals sit above the four mesh ports.
      fe_el_s = (fe_l_s == 32'd0) ? 32'd0 : 32'd4 + fe_l_s;
    end else if (id32_s < S_BASE) begin
      fe_x_s  = id32_s - N_BASE;
      fe_el_s = 32'd2;
    end else if (id32_s < W_BASE) begin
      fe_x_s  = id32_s - S_BASE;
      fe_y_s  = NY_U - 32'd1;
      fe_el_s = 32'd4;
    end else if (id32_s < E_BASE) begin
      fe_y_s  = id32_s - W_BASE;
      fe_el_s = 32'd3;
    end else begin
      fe_x_s  = NX_U - 32'd1;
      fe_y_s  = id32_s - E_BASE;
      fe_el_s = 32'd1;
    end
    if (fm_enc_err_s) begin
      fm_code_s = '0;
    end else begin
      fm_code_s = CW'(fe_x_s | (fe_y_s << XW) | (fe_el_s << (XW + YW)));
    end
  end

  // fmesh decode: exact inverse of encode; edge ports only exist on the matching edge.
  always_comb begin
    fd_x_s       = 32'(bus.code_in[XW-1:0]);
    fd_y_s       = 32'(bus.code_in[XW+YW-1:XW]);
    fd_el_s      = 32'(bus.code_in[FMW-1:XW+YW]);
    fm_dec_err_s = 1'b0;
    fd_id_s      = 32'd0;
    if ((fd_x_s >= NX_U) || (fd_y_s >= NY_U) || (fd_el_s >= P_U)) begin
      fm_dec_err_s = 1'b1;
    end else begin
      case (fd_el_s)
        32'd0: fd_id_s = (fd_y_s * NX_U + fd_x_s) * NL_U;
        32'd1: begin
          if (fd_x_s == NX_U - 32'd1) fd_id_s = E_BASE + fd_y_s;
          else fm_dec_err_s = 1'b1;
        end
        32'd2: begin
          if (fd_y_s == 32'd0) fd_id_s = N_BASE + fd_x_s;
          else fm_dec_err_s = 1'b1;
        end
        32'd3: begin
          if (fd_x_s == 32'd0) fd_id_s = W_BASE + fd_y_s;
          else fm_dec_err_s = 1'b1;
        end
        32'd4: begin
          if (fd_y_s == NY_U - 32'd1) fd_id_s = S_BASE + fd_x_s;
          else fm_dec_err_s = 1'b1;
        end
        default: fd_id_s = (fd_y_s * NX_U + fd_x_s) * NL_U + (fd_el_s - 32'd4);
      endcase
    end
    if (fm_dec_err_s) begin
      fm_id_s = '0;
    end else begin
      fm_id_s = IDW'(fd_id_s);
    end
  end

  // Select the result of the requested op; the output the op does not produce is 0.
  always_comb begin
    nxt_code_s = '0;
    nxt_id_s   = '0;
    nxt_err_s  = 1'b0;
    case (bus.op)
      2'd0: begin nxt_code_s = ft_code_s; nxt_err_s = ft_enc_err_s; end
      2'd1: begin nxt_id_s   = ft_id_s;   nxt_err_s = ft_dec_err_s; end
      2'd2: begin nxt_code_s = fm_code_s; nxt_err_s = fm_enc_err_s; end
      2'd3: begin nxt_id_s   = fm_id_s;   nxt_err_s = fm_dec_err_s; end
      default: begin nxt_code_s = '0; nxt_id_s = '0; nxt_err_s = 1'b0; end
    endcase
  end

  // Response register: results load only on a request, otherwise they hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      code_out_r  <= '0;
      id_out_r    <= '0;
      err_r       <= 1'b0;
    end else if (bus.in_valid) begin
      out_valid_r <= 1'b1;
      code_out_r  <= nxt_code_s;
      id_out_r    <= nxt_id_s;
      err_r       <= nxt_err_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.code_out  = code_out_r;
  assign bus.id_out    = id_out_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_noc_endp_addr_codec.sv
// Self-checking bench for noc_endp_addr_codec: default parameters (instance a)
// and a second parameter set K=2 L=3 NX=4 NY=2 NL=2 (instance b).
// Expected values come from hand-written vectors and a reference model that
// encodes from the topology rules and decodes by searching all endpoints.
module tb_noc_endp_addr_codec;

  function automatic int clog2m(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int K_A = 4, L_A = 2, NX_A = 3, NY_A = 3, NL_A = 1;
  localparam int K_B = 2, L_B = 3, NX_B = 4, NY_B = 2, NL_B = 2;

  function automatic int cw_of(int k, int l, int nx, int ny, int nl);
    int ft = l * clog2m(k);
    int fm = clog2m(nx) + clog2m(ny) + clog2m(4 + nl);
    return (ft > fm) ? ft : fm;
  endfunction

  function automatic int idw_of(int k, int l, int nx, int ny, int nl);
    int nt = k ** l;
    int nf = nx * ny * nl + 2 * nx + 2 * ny;
    return clog2m((nt > nf) ? nt : nf);
  endfunction

  localparam int CW_A  = cw_of(K_A, L_A, NX_A, NY_A, NL_A);
  localparam int IDW_A = idw_of(K_A, L_A, NX_A, NY_A, NL_A);
  localparam int CW_B  = cw_of(K_B, L_B, NX_B, NY_B, NL_B);
  localparam int IDW_B = idw_of(K_B, L_B, NX_B, NY_B, NL_B);

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   last_ec, last_eid;
  bit   last_ee;

  noc_endp_addr_codec_if #(.IDW(IDW_A), .CW(CW_A)) bus_a ();
  noc_endp_addr_codec_if #(.IDW(IDW_B), .CW(CW_B)) bus_b ();

  noc_endp_addr_codec #(.K(K_A), .L(L_A), .NX(NX_A), .NY(NY_A), .NL(NL_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  noc_endp_addr_codec #(.K(K_B), .L(L_B), .NX(NX_B), .NY(NY_B), .NL(NL_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ft_enc(int id, int k, int l, output bit e);
    int kw = clog2m(k);
    int c  = 0;
    int t  = id;
    e = (id >= k ** l);
    if (e) return 0;
    for (int i = 0; i < l; i++) begin
      c = c | ((t % k) << (i * kw));
      t = t / k;
    end
    return c;
  endfunction

  function automatic int ft_dec(int code, int k, int l, output bit e);
    int mask = (1 << (l * clog2m(k))) - 1;
    bit de;
    for (int id = 0; id < k ** l; id++) begin
      if (ft_enc(id, k, l, de) == (code & mask)) begin
        e = 1'b0;
        return id;
      end
    end
    e = 1'b1;
    return 0;
  endfunction

  function automatic int fm_enc(int id, int nx, int ny, int nl, output bit e);
    int xw = clog2m(nx);
    int yw = clog2m(ny);
    int nloc = nx * ny * nl;
    int x, y, el, j;
    e = 1'b0;
    if (id >= nloc + 2 * nx + 2 * ny) begin
      e = 1'b1;
      return 0;
    end
    if (id < nloc) begin
      x  = (id / nl) % nx;
      y  = (id / nl) / nx;
      el = (id % nl == 0) ? 0 : 4 + id % nl;
    end else begin
      j = id - nloc;
      if (j < nx)                begin x = j;          y = 0;               el = 2; end
      else if (j < 2 * nx)       begin x = j - nx;     y = ny - 1;          el = 4; end
      else if (j < 2 * nx + ny)  begin x = 0;          y = j - 2 * nx;      el = 3; end
      else                       begin x = nx - 1;     y = j - 2 * nx - ny; el = 1; end
    end
    return x | (y << xw) | (el << (xw + yw));
  endfunction

  function automatic int fm_dec(int code, int nx, int ny, int nl, output bit e);
    int mask = (1 << (clog2m(nx) + clog2m(ny) + clog2m(4 + nl))) - 1;
    int nef  = nx * ny * nl + 2 * nx + 2 * ny;
    bit de;
    for (int id = 0; id < nef; id++) begin
      if (fm_enc(id, nx, ny, nl, de) == (code & mask)) begin
        e = 1'b0;
        return id;
      end
    end
    e = 1'b1;
    return 0;
  endfunction

  task automatic get_exp(input int k, l, nx, ny, nl, input logic [1:0] op,
                         input int id, input int code,
                         output int ec, output int eid, output bit ee);
    ec = 0;
    eid = 0;
    ee = 1'b0;
    case (op)
      2'd0: ec  = ft_enc(id, k, l, ee);
      2'd1: eid = ft_dec(code, k, l, ee);
      2'd2: ec  = fm_enc(id, nx, ny, nl, ee);
      default: eid = fm_dec(code, nx, ny, nl, ee);
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, want 0x%0h", tag, field, act, exp);
    end
  endtask

  task automatic apply_a(input logic [1:0] op, input int id, input int code,
                         input int ec, input int eid, input bit ee, input string tag);
    bus_a.in_valid = 1'b1;
    bus_a.op       = op;
    bus_a.id_in    = IDW_A'(id);
    bus_a.code_in  = CW_A'(code);
    @(posedge clk);
    #1;
    check(tag, "valid", 32'(bus_a.out_valid), 32'd1);
    check(tag, "code",  32'(bus_a.code_out),  32'(ec));
    check(tag, "id",    32'(bus_a.id_out),    32'(eid));
    check(tag, "err",   32'(bus_a.err),       32'(ee));
    last_ec  = ec;
    last_eid = eid;
    last_ee  = ee;
  endtask

  task automatic model_a(input logic [1:0] op, input int id, input int code, input string tag);
    int ec, eid;
    bit ee;
    get_exp(K_A, L_A, NX_A, NY_A, NL_A, op, id, code, ec, eid, ee);
    apply_a(op, id, code, ec, eid, ee, tag);
  endtask

  task automatic idle_a(input string tag);
    bus_a.in_valid = 1'b0;
    bus_a.op       = 2'($urandom_range(3, 0));
    bus_a.id_in    = IDW_A'($urandom_range(31, 0));
    bus_a.code_in  = CW_A'($urandom_range(127, 0));
    @(posedge clk);
    #1;
    check(tag, "valid", 32'(bus_a.out_valid), 32'd0);
    check(tag, "code",  32'(bus_a.code_out),  32'(last_ec));
    check(tag, "id",    32'(bus_a.id_out),    32'(last_eid));
    check(tag, "err",   32'(bus_a.err),       32'(last_ee));
  endtask

  task automatic model_b(input logic [1:0] op, input int id, input int code, input string tag);
    int ec, eid;
    bit ee;
    get_exp(K_B, L_B, NX_B, NY_B, NL_B, op, id, code, ec, eid, ee);
    bus_b.in_valid = 1'b1;
    bus_b.op       = op;
    bus_b.id_in    = IDW_B'(id);
    bus_b.code_in  = CW_B'(code);
    @(posedge clk);
    #1;
    check(tag, "valid", 32'(bus_b.out_valid), 32'd1);
    check(tag, "code",  32'(bus_b.code_out),  32'(ec));
    check(tag, "id",    32'(bus_b.id_out),    32'(eid));
    check(tag, "err",   32'(bus_b.err),       32'(ee));
  endtask

  typedef struct {
    logic [1:0] op;
    int         id;
    int         code;
    int         ec;
    int         eid;
    bit         ee;
  } vec_t;

  vec_t tbl [0:22];

  initial begin
    int id_r;
    n_cmp  = 0;
    n_fail = 0;

    // Hand-derived vectors for the default parameters (code = el<<4 | y<<2 | x).
    tbl[0]  = '{2'd0, 6,  0,    32'h06, 0,  1'b0};  // digits 2,1
    tbl[1]  = '{2'd1, 0,  6,    0,      6,  1'b0};
    tbl[2]  = '{2'd0, 16, 0,    0,      0,  1'b1};  // first out-of-range ID
    tbl[3]  = '{2'd0, 15, 0,    32'h0F, 0,  1'b0};  // last legal ID
    tbl[4]  = '{2'd1, 0,  32'h7F, 0,    15, 1'b0};  // upper code bits ignored
    tbl[5]  = '{2'd2, 5,  0,    32'h06, 0,  1'b0};  // x=2 y=1 local
    tbl[6]  = '{2'd2, 9,  0,    32'h20, 0,  1'b0};  // north x=0, port 2
    tbl[7]  = '{2'd2, 13, 0,    32'h49, 0,  1'b0};  // south x=1 y=2
    tbl[8]  = '{2'd2, 20, 0,    32'h1A, 0,  1'b0};  // east y=2
    tbl[9]  = '{2'd2, 21, 0,    0,      0,  1'b1};  // first out-of-range ID
    tbl[10] = '{2'd2, 0,  0,    32'h00, 0,  1'b0};
    tbl[11] = '{2'd2, 8,  0,    32'h0A, 0,  1'b0};  // last local
    tbl[12] = '{2'd3, 0,  32'h03, 0,    0,  1'b1};  // x=3
    tbl[13] = '{2'd3, 0,  32'h24, 0,    0,  1'b1};  // north port, y=1
    tbl[14] = '{2'd3, 0,  32'h50, 0,    0,  1'b1};  // el=5 with NL=1
    tbl[15] = '{2'd3, 0,  32'h49, 0,    13, 1'b0};
    tbl[16] = '{2'd3, 0,  32'h1A, 0,    20, 1'b0};
    tbl[17] = '{2'd3, 0,  32'h20, 0,    9,  1'b0};
    tbl[18] = '{2'd3, 0,  32'h0C, 0,    0,  1'b1};  // y=3
    tbl[19] = '{2'd3, 0,  32'h60, 0,    0,  1'b1};  // el=6
    tbl[20] = '{2'd3, 0,  32'h06, 0,    5,  1'b0};
    tbl[21] = '{2'd3, 0,  32'h11, 0,    0,  1'b1};  // east port, x=1
    tbl[22] = '{2'd3, 0,  32'h30, 0,    15, 1'b0};  // west y=0

    // Reset held with a live request: outputs stay zero.
    reset          = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.op       = 2'd0;
    bus_a.id_in    = IDW_A'(6);
    bus_a.code_in  = '0;
    bus_b.in_valid = 1'b0;
    bus_b.op       = 2'd0;
    bus_b.id_in    = '0;
    bus_b.code_in  = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset", "valid", 32'(bus_a.out_valid), 32'd0);
      check("reset", "code",  32'(bus_a.code_out),  32'd0);
      check("reset", "id",    32'(bus_a.id_out),    32'd0);
      check("reset", "err",   32'(bus_a.err),       32'd0);
    end
    check("reset_b", "valid", 32'(bus_b.out_valid), 32'd0);
    reset = 1'b0;
    apply_a(2'd0, 6, 0, 32'h06, 0, 1'b0, "first");

    // Table vectors, back to back.
    for (int i = 0; i <= 22; i++) begin
      apply_a(tbl[i].op, tbl[i].id, tbl[i].code, tbl[i].ec, tbl[i].eid, tbl[i].ee,
              $sformatf("tbl%0d", i));
    end
    idle_a("idle1");

    // Exhaustive sweeps for the default set.
    for (int i = 0; i < 32; i++) model_a(2'd0, i, 0, "a_ftenc");
    for (int i = 0; i < 128; i++) model_a(2'd1, 0, i, "a_ftdec");
    for (int i = 0; i < 32; i++) model_a(2'd2, i, 0, "a_fmenc");
    for (int i = 0; i < 128; i++) model_a(2'd3, 0, i, "a_fmdec");

    // Alternating ft encode / fm decode with no idle cycles, then one idle.
    for (int i = 0; i < 40; i++) begin
      bit de;
      id_r = int'($urandom_range(31, 0));
      if (i % 2 == 0) model_a(2'd0, id_r, 0, "b2b_ft");
      else model_a(2'd3, 0, fm_enc(id_r % 22, NX_A, NY_A, NL_A, de) | int'($urandom_range(1, 0) << 1), "b2b_fm");
    end
    idle_a("idle2");

    // Random mix for the default set.
    for (int i = 0; i < 150; i++) begin
      model_a(2'($urandom_range(3, 0)), int'($urandom_range(31, 0)),
              int'($urandom_range(127, 0)), "a_rand");
    end
    idle_a("idle3");

    // Second parameter set: full sweeps cover range limits and round trips.
    for (int i = 0; i < 32; i++) model_b(2'd0, i, 0, "b_ftenc");
    for (int i = 0; i < 64; i++) model_b(2'd1, 0, i, "b_ftdec");
    for (int i = 0; i < 32; i++) model_b(2'd2, i, 0, "b_fmenc");
    for (int i = 0; i < 64; i++) model_b(2'd3, 0, i, "b_fmdec");
    for (int i = 0; i < 60; i++) begin
      model_b(2'($urandom_range(3, 0)), int'($urandom_range(31, 0)),
              int'($urandom_range(63, 0)), "b_rand");
    end
    bus_b.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b_idle", "valid", 32'(bus_b.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
